// File: rtl/tick_period_monitor_pkg.sv
// Shared state encoding and error-counter helpers for the tick period monitor.
package tick_period_monitor_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StHunt   = 2'b01,
      StCheck  = 2'b10,
      StLocked = 2'b11
   } mon_state_e;

   localparam int unsigned ErrCntW = 8;

   function automatic logic [ErrCntW-1:0] err_cnt_inc(input logic [ErrCntW-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Rising-edge detector for the strobe under test; TICK_SYNC_EN adds a 2-flop synchroniser.
module tick_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   output logic edge_o
);

   logic tick_s;
   logic tick_prev_q;

`ifdef TICK_SYNC_EN
   logic [1:0] sync_q;

   // Reset high so a strobe already high at release is not seen as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], tick_i};
      end
   end

   assign tick_s = sync_q[1];
`else
   assign tick_s = tick_i;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_prev_q <= 1'b1;
      end else begin
         tick_prev_q <= tick_s;
      end
   end

   assign edge_o = tick_s & ~tick_prev_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Measures strobe periods, tracks lock and counts period errors.
// Optional input synchroniser selected by TICK_SYNC_EN.
module tick_period_monitor
   import tick_period_monitor_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned EXP_PERIOD = 4,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned LOSS_CNT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               tick_in,
   output logic [CNT_W-1:0]   period_out,
   output logic               period_vld,
   output logic               locked,
   output logic               err_pulse,
   output logic [ErrCntW-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CycMax = '1;
   localparam logic [CNT_W-1:0] ExpP   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] LockN  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] LossN  = CNT_W'(LOSS_CNT);

   mon_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   good_q, good_d;
   logic [CNT_W-1:0]   bad_q, bad_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               vld_q, vld_d;
   logic               lock_q, lock_d;
   logic               errp_q, errp_d;
   logic [ErrCntW-1:0] errc_q, errc_d;

   logic tick_edge;
   logic measuring;
   logic good_edge;
   logic err;

   tick_edge_sync u_edge (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick_in),
      .edge_o (tick_edge)
   );

   assign measuring = (state_q == StCheck) || (state_q == StLocked);
   assign good_edge = tick_edge && (cyc_q == ExpP);
   // Timeout fires once per gap because cyc only passes EXP_PERIOD once before saturating.
   assign err = measuring && ((tick_edge && (cyc_q < ExpP)) || (!tick_edge && (cyc_q == ExpP)));

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      good_d   = good_q;
      bad_d    = bad_q;
      period_d = period_q;
      vld_d    = 1'b0;
      errp_d   = 1'b0;
      errc_d   = errc_q;

      if (!en) begin
         state_d = StIdle;
         cyc_d   = '0;
         good_d  = '0;
         bad_d   = '0;
      end else begin
         if (tick_edge) begin
            cyc_d = CNT_W'(1);
         end else if (cyc_q != CycMax) begin
            cyc_d = cyc_q + 1'b1;
         end

         if (measuring && tick_edge) begin
            vld_d    = 1'b1;
            period_d = cyc_q;
         end

         errp_d = err;
         if (err) begin
            errc_d = err_cnt_inc(errc_q);
         end

         unique case (state_q)
            StIdle: state_d = StHunt;
            StHunt: begin
               if (tick_edge) begin
                  state_d = StCheck;
                  good_d  = '0;
               end
            end
            StCheck: begin
               if (err) begin
                  good_d = '0;
               end else if (good_edge) begin
                  if (good_q + 1'b1 == LockN) begin
                     state_d = StLocked;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end
            end
            StLocked: begin
               if (err) begin
                  if (bad_q + 1'b1 == LossN) begin
                     state_d = StHunt;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + 1'b1;
                  end
               end else if (good_edge) begin
                  bad_d = '0;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      lock_d = (state_d == StLocked);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cyc_q    <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         period_q <= '0;
         vld_q    <= 1'b0;
         lock_q   <= 1'b0;
         errp_q   <= 1'b0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         period_q <= period_d;
         vld_q    <= vld_d;
         lock_q   <= lock_d;
         errp_q   <= errp_d;
         errc_q   <= errc_d;
      end
   end

   assign period_out = period_q;
   assign period_vld = vld_q;
   assign locked     = lock_q;
   assign err_pulse  = errp_q;
   assign err_cnt    = errc_q;

endmodule
